// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, LSB first, line idles high.
// The rx line is brought in through a two-flop synchroniser. A low level seen in idle
// starts a frame. The start bit is re-checked at mid-bit, and every later bit is sampled
// one bit period after the previous sample.
//
// Ports:
//   CLK           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   rx_serial     asynchronous serial input, idles high
//   rx_data       last correctly received byte, held until the next good frame
//   rx_valid      one-cycle strobe, rx_data is new in the same cycle
//   framing_error one-cycle strobe, stop bit sampled low
//   busy          high whenever the receiver is not idle
module uart_receiver #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       CLK,
   input  logic       reset_n,
   input  logic       rx_serial,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       framing_error,
   output logic       busy
);

   // Terminal counts. The counter starts at 0 on the edge after a sample point.
   localparam logic [15:0] HalfM1 = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] BitM1  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitIdle
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        sync1_q, sync2_q;
   logic        rx_sync;

   // The synchroniser resets to the idle level so that release from reset is not a start.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_serial;
         sync2_q <= sync1_q;
      end
   end

   assign rx_sync = sync2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_sync) state_d = StStart;
         end
         StStart: begin
            if (cnt_q == HalfM1) begin
               cnt_d   = '0;
               idx_d   = '0;
               // A start bit that is high again at mid-bit was a glitch.
               state_d = rx_sync ? StIdle : StData;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StData: begin
            if (cnt_q == BitM1) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_sync;
               if (idx_q == 3'd7) state_d = StStop;
               else               idx_d   = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StStop: begin
            if (cnt_q == BitM1) begin
               cnt_d = '0;
               if (rx_sync) begin
                  // Idle is re-entered at mid-stop-bit so that a back-to-back start is caught.
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StWaitIdle;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StWaitIdle: begin
            // A held-low (break) line must not retrigger a frame on every bit period.
            if (rx_sync) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_data       = data_q;
   assign rx_valid      = valid_q;
   assign framing_error = ferr_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: bench for uart_receiver. Instance 0 uses CLKS_PER_BIT=4 for directed
// and random frames. Instance 1 uses 434 for frames sent with a skewed bit period.
// A time-stepped reference model predicts every output on every cycle.
module tb_uart_receiver;

   logic       CLK;
   logic       reset_n;
   logic       rx0, rx1;
   logic [7:0] data0, data1;
   logic       valid0, valid1, fe0, fe1, busy0, busy1;

   uart_receiver #(.CLKS_PER_BIT(4)) u_dut0 (
      .CLK           (CLK),
      .reset_n       (reset_n),
      .rx_serial     (rx0),
      .rx_data       (data0),
      .rx_valid      (valid0),
      .framing_error (fe0),
      .busy          (busy0)
   );

   uart_receiver #(.CLKS_PER_BIT(434)) u_dut1 (
      .CLK           (CLK),
      .reset_n       (reset_n),
      .rx_serial     (rx1),
      .rx_data       (data1),
      .rx_valid      (valid1),
      .framing_error (fe1),
      .busy          (busy1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] exp_data [2];
   logic       exp_valid[2];
   logic       exp_fe   [2];
   logic       exp_busy [2];
   logic [1:0] msync    [2];

   // One clock edge: returns the synchronised line value the receiver acts on at this edge.
   task automatic tick(input int id, output logic sy, output bit rst);
      @(posedge CLK);
      exp_valid[id] = 1'b0;
      exp_fe[id]    = 1'b0;
      if (!reset_n) begin
         rst           = 1'b1;
         sy            = 1'b1;
         msync[id]     = 2'b11;
         exp_data[id]  = 8'h00;
         exp_busy[id]  = 1'b0;
      end else begin
         rst       = 1'b0;
         sy        = msync[id][1];
         msync[id] = {msync[id][0], (id == 0) ? rx0 : rx1};
      end
   endtask

   task automatic wait_n(input int id, input int n, output logic sy, output bit rst);
      sy  = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick(id, sy, rst);
         if (rst) return;
      end
   endtask

   task automatic model(input int id, input int cpb);
      logic       sy;
      bit         rst;
      logic [7:0] sh;
      sh = 8'h00;
      forever begin
         tick(id, sy, rst);
         if (rst || sy) continue;
         exp_busy[id] = 1'b1;
         wait_n(id, cpb / 2, sy, rst);
         if (rst) continue;
         if (sy) begin
            exp_busy[id] = 1'b0;
            continue;
         end
         for (int b = 0; b < 8; b++) begin
            wait_n(id, cpb, sy, rst);
            if (rst) break;
            sh[b] = sy;
         end
         if (rst) continue;
         wait_n(id, cpb, sy, rst);
         if (rst) continue;
         if (sy) begin
            exp_valid[id] = 1'b1;
            exp_data[id]  = sh;
            exp_busy[id]  = 1'b0;
         end else begin
            exp_fe[id] = 1'b1;
            do tick(id, sy, rst); while (!rst && !sy);
            exp_busy[id] = 1'b0;
         end
      end
   endtask

   // ---------------- compare + monitor ----------------
   int         cyc = 0;
   int         valid_cnt[2];
   int         fe_cnt[2];
   int         busy_cnt0 = 0;
   logic [7:0] got_data0[$];
   int         got_cyc0[$];
   bit         cmp_en = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("data0", data0, exp_data[0]);
         chk("valid0", valid0, exp_valid[0]);
         chk("ferr0", fe0, exp_fe[0]);
         chk("busy0", busy0, exp_busy[0]);
         chk("data1", data1, exp_data[1]);
         chk("valid1", valid1, exp_valid[1]);
         chk("ferr1", fe1, exp_fe[1]);
         chk("busy1", busy1, exp_busy[1]);
         if (valid0) begin
            valid_cnt[0]++;
            got_data0.push_back(data0);
            got_cyc0.push_back(cyc);
         end
         if (valid1) valid_cnt[1]++;
         if (fe0) fe_cnt[0]++;
         if (fe1) fe_cnt[1]++;
         if (busy0) busy_cnt0++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input int id, input logic v, input int cycles);
      if (id == 0) rx0 = v;
      else         rx1 = v;
      repeat (cycles) begin
         @(negedge CLK);
         #1;
      end
   endtask

   task automatic send_frame(input int id, input logic [7:0] d, input logic stop,
                             input int period);
      drive(id, 1'b0, period);
      for (int b = 0; b < 8; b++) drive(id, d[b], period);
      drive(id, stop, period);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int         v, f, bc, good;
      logic [7:0] last_good;
      logic [7:0] rb;
      bit         bad;
      for (int i = 0; i < 2; i++) begin
         exp_data[i]  = 8'h00;
         exp_valid[i] = 1'b0;
         exp_fe[i]    = 1'b0;
         exp_busy[i]  = 1'b0;
         msync[i]     = 2'b11;
         valid_cnt[i] = 0;
         fe_cnt[i]    = 0;
      end
      rx0     = 1'b1;
      rx1     = 1'b1;
      reset_n = 1'b0;
      fork
         model(0, 4);
         model(1, 434);
      join_none
      @(negedge CLK);
      cmp_en = 1'b1;
      #1;
      repeat (2) begin
         @(negedge CLK);
         #1;
      end
      reset_n = 1'b1;
      chk("reset_data", data0, 8'h00);
      chk("reset_busy", busy0, 1'b0);
      drive(0, 1'b1, 10);

      // 1: single frame 0xA5
      v = valid_cnt[0];
      f = fe_cnt[0];
      send_frame(0, 8'hA5, 1'b1, 4);
      drive(0, 1'b1, 8);
      chk("t1_valid_count", valid_cnt[0] - v, 1);
      chk("t1_data", got_data0[$], 8'hA5);
      chk("t1_ferr_count", fe_cnt[0] - f, 0);

      // 2: back-to-back 0x00 then 0xFF
      v = valid_cnt[0];
      send_frame(0, 8'h00, 1'b1, 4);
      send_frame(0, 8'hFF, 1'b1, 4);
      drive(0, 1'b1, 8);
      chk("t2_valid_count", valid_cnt[0] - v, 2);
      chk("t2_first_data", got_data0[$-1], 8'h00);
      chk("t2_second_data", got_data0[$], 8'hFF);
      chk("t2_gap", got_cyc0[$] - got_cyc0[$-1], 40);

      // 3: one-cycle glitch in idle
      v  = valid_cnt[0];
      f  = fe_cnt[0];
      bc = busy_cnt0;
      drive(0, 1'b0, 1);
      drive(0, 1'b1, 10);
      chk("t3_busy_cycles", busy_cnt0 - bc, 2);
      chk("t3_valid_count", valid_cnt[0] - v, 0);
      chk("t3_ferr_count", fe_cnt[0] - f, 0);
      chk("t3_data", data0, 8'hFF);

      // 4: framing error, held break, then good frame
      v = valid_cnt[0];
      f = fe_cnt[0];
      send_frame(0, 8'h3C, 1'b0, 4);
      drive(0, 1'b0, 30);
      drive(0, 1'b1, 8);
      chk("t4_ferr_count", fe_cnt[0] - f, 1);
      chk("t4_valid_count", valid_cnt[0] - v, 0);
      chk("t4_data_held", data0, 8'hFF);
      send_frame(0, 8'h81, 1'b1, 4);
      drive(0, 1'b1, 8);
      chk("t4_valid_after", valid_cnt[0] - v, 1);
      chk("t4_data_after", data0, 8'h81);

      // 5: reset during data bit 4 of 0x5A
      v = valid_cnt[0];
      drive(0, 1'b0, 4);
      for (int b = 0; b < 4; b++) drive(0, rb_bit(8'h5A, b), 4);
      drive(0, rb_bit(8'h5A, 4), 1);
      reset_n = 1'b0;
      rx0     = 1'b1;
      #1;
      chk("t5_async_data", data0, 8'h00);
      chk("t5_async_busy", busy0, 1'b0);
      chk("t5_async_valid", valid0, 1'b0);
      chk("t5_async_ferr", fe0, 1'b0);
      repeat (2) begin
         @(negedge CLK);
         #1;
      end
      reset_n = 1'b1;
      drive(0, 1'b1, 50);
      chk("t5_no_partial", valid_cnt[0] - v, 0);
      chk("t5_data_cleared", data0, 8'h00);
      send_frame(0, 8'h5A, 1'b1, 4);
      drive(0, 1'b1, 8);
      chk("t5_valid_after", valid_cnt[0] - v, 1);
      chk("t5_data_after", data0, 8'h5A);

      // random frames, some with a low stop bit followed by a break
      good      = 0;
      last_good = data0;
      v         = valid_cnt[0];
      for (int n = 0; n < 40; n++) begin
         rb  = 8'($urandom);
         bad = ($urandom_range(0, 5) == 0);
         if (bad) begin
            send_frame(0, rb, 1'b0, 4);
            drive(0, 1'b0, $urandom_range(0, 20));
            drive(0, 1'b1, $urandom_range(1, 6));
         end else begin
            send_frame(0, rb, 1'b1, 4);
            good++;
            last_good = rb;
            drive(0, 1'b1, $urandom_range(0, 6));
         end
      end
      drive(0, 1'b1, 10);
      chk("rand_valid_count", valid_cnt[0] - v, good);
      chk("rand_last_data", data0, last_good);

      // 6: CLKS_PER_BIT=434, transmitter 3% slow then 3% fast
      v = valid_cnt[1];
      f = fe_cnt[1];
      send_frame(1, 8'h42, 1'b1, 447);
      drive(1, 1'b1, 500);
      send_frame(1, 8'h42, 1'b1, 421);
      drive(1, 1'b1, 500);
      chk("t6_valid_count", valid_cnt[1] - v, 2);
      chk("t6_data", data1, 8'h42);
      chk("t6_ferr_count", fe_cnt[1] - f, 0);

      @(negedge CLK);
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   function automatic logic rb_bit(input logic [7:0] d, input int b);
      return d[b];
   endfunction

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the far-end partner of the team's UART transmitter.
- Frame format: 8N1, LSB first. Line idles high; start bit = 0; stop bit = 1.
- Synchronises the asynchronous rx line, validates the start bit, and samples each bit at mid-bit.
- Delivers each byte with a one-cycle valid strobe and flags framing errors.

Parameters:
CLKS_PER_BIT, 4, clock cycles per bit period. Production value is 434 (50 MHz / 115200). Legal range 4..65535.

Ports:
CLK  input  1  system clock; all logic on the rising edge
reset_n  input  1  asynchronous, active-low reset
rx_serial  input  1  asynchronous serial data line; idles high
rx_data  output  8  last correctly received byte; holds until the next good frame
rx_valid  output  1  one-cycle pulse; rx_data is new and valid in the same cycle
framing_error  output  1  one-cycle pulse; stop bit sampled as 0
busy  output  1  high while a frame is in progress (any state other than IDLE)

Behaviour:
- Reset: while reset_n=0, regardless of CLK:
  - rx_data=0x00, rx_valid=0, framing_error=0, busy=0.
  - State=IDLE; bit counter and bit index cleared.
  - Both synchroniser flops set to 1.
- Synchroniser: 2-flop synchroniser on rx_serial; the FSM sees only rx_sync. Latency is 2 cycles.
- HALF = CLKS_PER_BIT/2 (integer division). Cycle counter is 16 bits wide; bit index is 3 bits wide.
- Cycle T0: the edge on which the FSM is in IDLE and sees rx_sync=0.
- Sample points: T0+HALF+k*CLKS_PER_BIT for k=0 (start bit), k=1..8 (data bits 0..7), k=9 (stop bit).
- States:
  - IDLE: busy=0, counter=0. If rx_sync=0, go to START.
  - START: count to HALF. At the sample point:
    - rx_sync=1: glitch; return to IDLE with no outputs asserted.
    - rx_sync=0: clear counter, index=0, go to DATA.
  - DATA: count to CLKS_PER_BIT-1. At each sample, shift rx_sync into bit [index] of an internal shift register.
    - After index 7 is sampled, go to STOP.
    - rx_data is not touched during DATA.
  - STOP: at the stop sample point:
    - rx_sync=1: rx_data<=shift register; rx_valid=1 for exactly the next cycle; go to IDLE.
    - rx_sync=0: framing_error=1 for exactly the next cycle; rx_data unchanged; go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_sync=1, then go to IDLE. This prevents a break condition from retriggering continuously.
- Back-to-back frames:
  - IDLE is re-entered at mid-stop-bit, so the next start edge is caught with no gap required.
  - rx_valid for frame n and the start detect of frame n+1 must both work correctly.
- Invalid state encodings return to IDLE.
- rx_valid and framing_error are never high in the same cycle.
- Reset mid-frame: all outputs return to reset values immediately and the partial byte is discarded. After release, the receiver waits for a fresh falling edge. Continuous low on release is treated as a start.

Test Plan:
1. CLKS_PER_BIT=4: drive frame for 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) -> single rx_valid pulse, rx_data=0xA5, framing_error=0, busy falls after stop sample.
2. Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses exactly 10*CLKS_PER_BIT cycles apart; rx_data=0x00 then 0xFF.
3. 1-cycle low glitch on rx_serial during IDLE -> busy pulses briefly, no rx_valid, no framing_error, rx_data unchanged.
4. Frame 0x3C with stop bit driven 0, line held low 30 cycles, then high, then good frame 0x81 -> exactly one framing_error pulse, rx_data stays at prior value, then rx_valid with rx_data=0x81.
5. Assert reset_n=0 for 2 cycles during data bit 4 of frame 0x5A -> outputs at reset values asynchronously, no rx_valid for the partial frame. A subsequent 0x5A frame is received correctly.
6. CLKS_PER_BIT=434, frame 0x42 with transmitter bit period skewed ±3% -> rx_data=0x42, rx_valid once.
